// File: rtl/pa2se_ifft_feed.sv
// pa2se_ifft_feed: transmit-side parallel-to-serial feeder for the IFFT.
//
// One frame of N_CH parallel complex channel samples (IN_W-bit signed
// real/imag) is captured when every channel is valid and a buffer is free.
// Each component is rounded (half-up) and saturated to OUT_W bits, stored
// into one half of a ping-pong buffer, and streamed out as N_CH serial beats
// on an AXI-Stream style slave port of the IFFT.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   tx_sig_real/imag     per-channel signed samples, IN_W bits each
//   tx_sig_tvalid        per-channel valid; a frame needs all bits set
//   tx_sig_tready        a free buffer exists (decoded from flops only)
//   ifft_s_data_tdata    {imag, real} of the current beat, OUT_W bits each
//   ifft_s_data_tuser    channel index of the current beat
//   ifft_s_data_tvalid   beat valid
//   ifft_s_data_tlast    last beat of the frame
//   ifft_s_data_tready   IFFT accepts the beat
//   frame_err            sticky: a partially valid frame was presented
//   sat_flag             sticky: a captured component was clipped
//
// Build option:
//   BIT_REVERSE_IN_EN    when defined, beats leave in bit-reversed channel
//                        order (0,4,2,6,1,5,3,7 for N_CH=8); tuser carries
//                        the reversed index, tlast still marks the 8th beat.

module pa2se_ifft_feed #(
  parameter int unsigned N_CH  = 8,
  parameter int unsigned IN_W  = 20,
  parameter int unsigned OUT_W = 16
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic signed [N_CH-1:0][IN_W-1:0]    tx_sig_real,
  input  logic signed [N_CH-1:0][IN_W-1:0]    tx_sig_imag,
  input  logic        [N_CH-1:0]              tx_sig_tvalid,
  output logic                                tx_sig_tready,
  output logic        [2*OUT_W-1:0]           ifft_s_data_tdata,
  output logic        [$clog2(N_CH)-1:0]      ifft_s_data_tuser,
  output logic                                ifft_s_data_tvalid,
  output logic                                ifft_s_data_tlast,
  input  logic                                ifft_s_data_tready,
  output logic                                frame_err,
  output logic                                sat_flag
);

  localparam int unsigned CNT_W = $clog2(N_CH);
  localparam int unsigned TD_W  = 2 * OUT_W;
  localparam int unsigned SHIFT = IN_W - OUT_W;
  // One guard bit so the rounding addition cannot wrap.
  localparam int unsigned SUM_W = IN_W + 1;

  localparam logic signed [SUM_W-1:0] RND     = SUM_W'(2 ** (SHIFT - 1));
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = -SAT_MAX - SUM_W'(1);
  localparam logic        [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic        [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic        [CNT_W-1:0] CNT_LAST = CNT_W'(N_CH - 1);

  // Round half-up then saturate; MSB of the result flags a clip.
  function automatic logic [OUT_W:0] round_sat(input logic [IN_W-1:0] x);
    logic signed [SUM_W-1:0] ext;
    logic signed [SUM_W-1:0] rnd;
    logic        [OUT_W:0]   res;
    ext = $signed({x[IN_W-1], x});
    rnd = (ext + RND) >>> SHIFT;
    if (rnd > SAT_MAX) begin
      res = {1'b1, OUT_MAX};
    end else if (rnd < SAT_MIN) begin
      res = {1'b1, OUT_MIN};
    end else begin
      res = {1'b0, rnd[OUT_W-1:0]};
    end
    return res;
  endfunction

  // State
  logic [1:0]                      full_q, full_d;
  logic                            wsel_q, wsel_d;
  logic                            rsel_q, rsel_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic                            frame_err_q, frame_err_d;
  logic                            sat_q, sat_d;
  logic [1:0][N_CH-1:0][TD_W-1:0]  mem_q, mem_d;

  // Datapath / control decode
  logic [N_CH-1:0][TD_W-1:0]       conv_word;
  logic [N_CH-1:0]                 conv_sat;
  logic                            all_valid;
  logic                            any_valid;
  logic                            wr_frame;
  logic                            frame_partial;
  logic                            rd_valid;
  logic                            rd_beat;
  logic                            rd_last;
  logic [CNT_W-1:0]                idx;

  // Per-channel conversion of the incoming frame.
  always_comb begin
    logic [OUT_W:0] re_r;
    logic [OUT_W:0] im_r;
    re_r      = '0;
    im_r      = '0;
    conv_word = '0;
    conv_sat  = '0;
    for (int c = 0; c < int'(N_CH); c++) begin
      re_r         = round_sat(tx_sig_real[c]);
      im_r         = round_sat(tx_sig_imag[c]);
      conv_word[c] = {im_r[OUT_W-1:0], re_r[OUT_W-1:0]};
      conv_sat[c]  = re_r[OUT_W] | im_r[OUT_W];
    end
  end

  // Read index: natural or bit-reversed beat order.
`ifdef BIT_REVERSE_IN_EN
  always_comb begin
    idx = '0;
    for (int b = 0; b < int'(CNT_W); b++) begin
      idx[b] = cnt_q[int'(CNT_W) - 1 - b];
    end
  end
`else
  always_comb begin
    idx = cnt_q;
  end
`endif

  // Handshake decode, all from registered state plus live inputs.
  always_comb begin
    all_valid     = &tx_sig_tvalid;
    any_valid     = |tx_sig_tvalid;
    tx_sig_tready = ~full_q[wsel_q];
    wr_frame      = tx_sig_tready & all_valid;
    frame_partial = any_valid & ~all_valid;
    rd_valid      = full_q[rsel_q];
    rd_beat       = rd_valid & ifft_s_data_tready;
    rd_last       = (cnt_q == CNT_LAST);
  end

  // Next-state: drain one beat, capture one frame, track sticky flags.
  // Capture and release may coincide; they always target different buffers.
  always_comb begin
    full_d      = full_q;
    wsel_d      = wsel_q;
    rsel_d      = rsel_q;
    cnt_d       = cnt_q;
    mem_d       = mem_q;
    frame_err_d = frame_err_q;
    sat_d       = sat_q;

    if (rd_beat) begin
      if (rd_last) begin
        cnt_d          = '0;
        full_d[rsel_q] = 1'b0;
        rsel_d         = ~rsel_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    if (wr_frame) begin
      mem_d[wsel_q]  = conv_word;
      full_d[wsel_q] = 1'b1;
      wsel_d         = ~wsel_q;
      sat_d          = sat_q | (|conv_sat);
    end

    if (frame_partial) begin
      frame_err_d = 1'b1;
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      full_q      <= '0;
      wsel_q      <= 1'b0;
      rsel_q      <= 1'b0;
      cnt_q       <= '0;
      frame_err_q <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      full_q      <= full_d;
      wsel_q      <= wsel_d;
      rsel_q      <= rsel_d;
      cnt_q       <= cnt_d;
      frame_err_q <= frame_err_d;
      sat_q       <= sat_d;
    end
  end

  // Sample storage needs no reset: it is only visible while its full bit is set.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Output stream; data fields are zeroed while no beat is offered.
  always_comb begin
    ifft_s_data_tvalid = rd_valid;
    ifft_s_data_tdata  = rd_valid ? mem_q[rsel_q][idx] : '0;
    ifft_s_data_tuser  = rd_valid ? idx : '0;
    ifft_s_data_tlast  = rd_valid & rd_last;
    frame_err          = frame_err_q;
    sat_flag           = sat_q;
  end

endmodule
